// File: rtl/fwd_source_pipe_pkg.sv
// fwd_source_pipe_pkg
//   Shared definitions for the EX->MEM->WB result pipeline: the datapath and
//   register-address widths, the x0 address constant, and the per-stage
//   payload struct that the MEM and WB pipeline registers carry.
package fwd_source_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // Register x0 is hard-wired to zero and never written or forwarded.
    localparam logic [REG_AW-1:0] X0 = '0;

    // Payload of one pipeline stage. In the WB stage 'data' holds the
    // selected write-back value (load data or ALU result).
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic [DATA_W-1:0] data;
    } mem_stage_t;

endpackage : fwd_source_pipe_pkg

// File: rtl/fwd_source_pipe_stage_reg.sv
// pipe_stage_reg
//   Generic pipeline register with a freeze input and synchronous reset.
//   Used once for the MEM stage and once for the WB stage.
// Ports:
//   clk_i   rising-edge clock
//   rst_i   synchronous active-high reset, clears the register; beats hold_i
//   hold_i  when high the register keeps its value
//   d_i     next-stage payload
//   q_o     registered payload
module pipe_stage_reg #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         hold_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else if (!hold_i) begin
            q_o <= d_i;
        end
    end

endmodule : pipe_stage_reg

// File: rtl/fwd_source_pipe.sv
// fwd_source_pipe
//   Carries EX results through the MEM and WB pipeline registers, producing
//   the destination / write-enable / data values used by the forwarding unit
//   and the register-file write port. Also flags load-use hazards against
//   the ID stage and counts the bubbles that the upstream logic inserts.
//   DATA_W and REG_AW must match the package values (the stage payload
//   struct is sized from the package).
// Ports:
//   clk, rst               clock, synchronous active-high reset (beats hold)
//   hold                   global freeze; no stage advances, no counting
//   ex_valid, rd_ex,
//   reg_write_ex,
//   mem_read_ex,
//   alu_result_ex          EX-stage instruction fields
//   rs1_id, rs2_id         ID-stage source registers for hazard compare
//   mem_rdata              data-memory read data for the load in MEM
//   rd_mem, reg_write_mem,
//   fwd_ok_mem,
//   alu_result_mem         MEM-stage outputs (alu_result_mem = mem address)
//   rd_wb, reg_write_wb,
//   wb_data                register-file write port
//   stall_id               load-use stall request (combinational)
//   bubble_cnt             saturating count of load-use bubbles
module fwd_source_pipe #(
    parameter int DATA_W = fwd_source_pipe_pkg::DATA_W,
    parameter int REG_AW = fwd_source_pipe_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              reg_write_ex,
    input  logic              mem_read_ex,
    input  logic [DATA_W-1:0] alu_result_ex,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [REG_AW-1:0] rd_mem,
    output logic              reg_write_mem,
    output logic              fwd_ok_mem,
    output logic [DATA_W-1:0] alu_result_mem,
    output logic [REG_AW-1:0] rd_wb,
    output logic              reg_write_wb,
    output logic [DATA_W-1:0] wb_data,
    output logic              stall_id,
    output logic [CNT_W-1:0]  bubble_cnt
);

    import fwd_source_pipe_pkg::*;

    mem_stage_t       mem_d, mem_q;
    mem_stage_t       wb_d,  wb_q;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // NOTE: every always_comb output gets a full default first so no path
    // leaves a signal unassigned (which would infer a latch).
    always_comb begin
        mem_d           = '0;
        mem_d.valid     = ex_valid;
        mem_d.rd        = rd_ex;
        mem_d.reg_write = reg_write_ex;
        mem_d.mem_read  = mem_read_ex;
        mem_d.data      = alu_result_ex;

        // mem_rdata is valid during the load's MEM cycle, i.e. exactly at
        // the edge where the load moves from MEM into WB.
        wb_d      = mem_q;
        wb_d.data = mem_q.mem_read ? mem_rdata : mem_q.data;
    end

    pipe_stage_reg #(.W($bits(mem_stage_t))) u_mem_reg (
        .clk_i  (clk),
        .rst_i  (rst),
        .hold_i (hold),
        .d_i    (mem_d),
        .q_o    (mem_q)
    );

    pipe_stage_reg #(.W($bits(mem_stage_t))) u_wb_reg (
        .clk_i  (clk),
        .rst_i  (rst),
        .hold_i (hold),
        .d_i    (wb_d),
        .q_o    (wb_q)
    );

    // Write enables are qualified by valid and by rd != x0, so a bubble or a
    // write to x0 can never reach the register file or the forwarding mux.
    assign rd_mem         = mem_q.rd;
    assign reg_write_mem  = mem_q.valid & mem_q.reg_write & (mem_q.rd != X0);
    // A load's value is not known until the end of MEM, so it cannot be
    // forwarded from this stage.
    assign fwd_ok_mem     = reg_write_mem & ~mem_q.mem_read;
    assign alu_result_mem = mem_q.data;

    assign rd_wb          = wb_q.rd;
    assign reg_write_wb   = wb_q.valid & wb_q.reg_write & (wb_q.rd != X0);
    assign wb_data        = wb_q.data;

    // Load in EX whose destination is read by the instruction in ID.
    assign stall_id = ex_valid & mem_read_ex & reg_write_ex & (rd_ex != X0) &
                      ((rd_ex == rs1_id) | (rd_ex == rs2_id));

    // Count a bubble only on edges where the pipe actually advances; the
    // counter sticks at all-ones instead of wrapping.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (stall_id && !hold && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;

endmodule : fwd_source_pipe

// File: tb/tb_fwd_source_pipe.sv
// tb_fwd_source_pipe
//   Directed testbench for fwd_source_pipe. A second instance with a 3-bit
//   bubble counter shares all inputs so counter saturation can be reached in
//   a few cycles.
module tb_fwd_source_pipe;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              hold;
    logic              ex_valid;
    logic [REG_AW-1:0] rd_ex;
    logic              reg_write_ex;
    logic              mem_read_ex;
    logic [DATA_W-1:0] alu_result_ex;
    logic [REG_AW-1:0] rs1_id;
    logic [REG_AW-1:0] rs2_id;
    logic [DATA_W-1:0] mem_rdata;

    logic [REG_AW-1:0] rd_mem;
    logic              reg_write_mem;
    logic              fwd_ok_mem;
    logic [DATA_W-1:0] alu_result_mem;
    logic [REG_AW-1:0] rd_wb;
    logic              reg_write_wb;
    logic [DATA_W-1:0] wb_data;
    logic              stall_id;
    logic [CNT_W-1:0]  bubble_cnt;

    logic [REG_AW-1:0] s_rd_mem;
    logic              s_reg_write_mem;
    logic              s_fwd_ok_mem;
    logic [DATA_W-1:0] s_alu_result_mem;
    logic [REG_AW-1:0] s_rd_wb;
    logic              s_reg_write_wb;
    logic [DATA_W-1:0] s_wb_data;
    logic              s_stall_id;
    logic [2:0]        s_bubble_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fwd_source_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .hold           (hold),
        .ex_valid       (ex_valid),
        .rd_ex          (rd_ex),
        .reg_write_ex   (reg_write_ex),
        .mem_read_ex    (mem_read_ex),
        .alu_result_ex  (alu_result_ex),
        .rs1_id         (rs1_id),
        .rs2_id         (rs2_id),
        .mem_rdata      (mem_rdata),
        .rd_mem         (rd_mem),
        .reg_write_mem  (reg_write_mem),
        .fwd_ok_mem     (fwd_ok_mem),
        .alu_result_mem (alu_result_mem),
        .rd_wb          (rd_wb),
        .reg_write_wb   (reg_write_wb),
        .wb_data        (wb_data),
        .stall_id       (stall_id),
        .bubble_cnt     (bubble_cnt)
    );

    fwd_source_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(3)) dut_sat (
        .clk            (clk),
        .rst            (rst),
        .hold           (hold),
        .ex_valid       (ex_valid),
        .rd_ex          (rd_ex),
        .reg_write_ex   (reg_write_ex),
        .mem_read_ex    (mem_read_ex),
        .alu_result_ex  (alu_result_ex),
        .rs1_id         (rs1_id),
        .rs2_id         (rs2_id),
        .mem_rdata      (mem_rdata),
        .rd_mem         (s_rd_mem),
        .reg_write_mem  (s_reg_write_mem),
        .fwd_ok_mem     (s_fwd_ok_mem),
        .alu_result_mem (s_alu_result_mem),
        .rd_wb          (s_rd_wb),
        .reg_write_wb   (s_reg_write_wb),
        .wb_data        (s_wb_data),
        .stall_id       (s_stall_id),
        .bubble_cnt     (s_bubble_cnt)
    );

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ex_valid      = 1'b0;
        rd_ex         = '0;
        reg_write_ex  = 1'b0;
        mem_read_ex   = 1'b0;
        alu_result_ex = '0;
        rs1_id        = '0;
        rs2_id        = '0;
        mem_rdata     = '0;
    endtask

    task automatic drive_ex(input logic [REG_AW-1:0] rd, input logic rw,
                            input logic ld, input logic [DATA_W-1:0] alu);
        ex_valid      = 1'b1;
        rd_ex         = rd;
        reg_write_ex  = rw;
        mem_read_ex   = ld;
        alu_result_ex = alu;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        hold = 1'b1;  // reset must win over hold
        drive_idle();
        step();
        step();
        rst  = 1'b0;
        hold = 1'b0;
        n_total++;
        if ({rd_mem, reg_write_mem, fwd_ok_mem, alu_result_mem} !== '0) $display("FAIL reset_mem: got rd=%0d we=%b fwd=%b alu=%h, want all 0", rd_mem, reg_write_mem, fwd_ok_mem, alu_result_mem);
        else n_pass++;
        n_total++;
        if ({rd_wb, reg_write_wb, wb_data} !== '0) $display("FAIL reset_wb: got rd=%0d we=%b data=%h, want all 0", rd_wb, reg_write_wb, wb_data);
        else n_pass++;
        n_total++;
        if (bubble_cnt !== 32'd0 || stall_id !== 1'b0) $display("FAIL reset_cnt: got cnt=%0d stall=%b, want 0/0", bubble_cnt, stall_id);
        else n_pass++;
    endtask

    task automatic test_alu_forward();
        drive_ex(5'd5, 1'b1, 1'b0, 32'h0000_1234);
        step();
        drive_idle();
        n_total++;
        if (rd_mem !== 5'd5 || reg_write_mem !== 1'b1 || fwd_ok_mem !== 1'b1 || alu_result_mem !== 32'h1234)
            $display("FAIL alu_mem: got rd=%0d we=%b fwd=%b alu=%h, want 5/1/1/00001234", rd_mem, reg_write_mem, fwd_ok_mem, alu_result_mem);
        else n_pass++;
        step();
        n_total++;
        if (rd_wb !== 5'd5 || reg_write_wb !== 1'b1 || wb_data !== 32'h1234)
            $display("FAIL alu_wb: got rd=%0d we=%b data=%h, want 5/1/00001234", rd_wb, reg_write_wb, wb_data);
        else n_pass++;
        n_total++;
        if (reg_write_mem !== 1'b0) $display("FAIL alu_mem_bubble: got we=%b, want 0", reg_write_mem);
        else n_pass++;
    endtask

    task automatic test_load_use();
        // Load to r7 with no consumer in ID: no stall.
        drive_ex(5'd7, 1'b1, 1'b1, 32'h0000_0100);
        rs1_id = 5'd3;
        rs2_id = 5'd4;
        #1;
        n_total++;
        if (stall_id !== 1'b0) $display("FAIL load_nomatch_stall: got %b, want 0", stall_id);
        else n_pass++;
        // ALU op writing the register ID reads: forwardable, no stall.
        drive_ex(5'd7, 1'b1, 1'b0, 32'h0000_0100);
        rs2_id = 5'd7;
        #1;
        n_total++;
        if (stall_id !== 1'b0) $display("FAIL alu_match_stall: got %b, want 0", stall_id);
        else n_pass++;
        // Load to r7 consumed by rs2 in ID.
        drive_ex(5'd7, 1'b1, 1'b1, 32'h0000_0100);
        #1;
        n_total++;
        if (stall_id !== 1'b1) $display("FAIL load_use_stall: got %b, want 1", stall_id);
        else n_pass++;
        step();
        drive_idle();
        mem_rdata = 32'h0000_CAFE;
        n_total++;
        if (fwd_ok_mem !== 1'b0 || reg_write_mem !== 1'b1 || alu_result_mem !== 32'h100 || bubble_cnt !== 32'd1)
            $display("FAIL load_mem: got fwd=%b we=%b addr=%h cnt=%0d, want 0/1/00000100/1", fwd_ok_mem, reg_write_mem, alu_result_mem, bubble_cnt);
        else n_pass++;
        step();
        mem_rdata = '0;
        n_total++;
        if (wb_data !== 32'h0000_CAFE || rd_wb !== 5'd7 || reg_write_wb !== 1'b1 || bubble_cnt !== 32'd1)
            $display("FAIL load_wb: got data=%h rd=%0d we=%b cnt=%0d, want 0000cafe/7/1/1", wb_data, rd_wb, reg_write_wb, bubble_cnt);
        else n_pass++;
    endtask

    task automatic test_x0();
        drive_ex(5'd0, 1'b1, 1'b0, 32'h0000_0055);
        step();
        drive_idle();
        n_total++;
        if (reg_write_mem !== 1'b0 || fwd_ok_mem !== 1'b0) $display("FAIL x0_mem: got we=%b fwd=%b, want 0/0", reg_write_mem, fwd_ok_mem);
        else n_pass++;
        step();
        n_total++;
        if (reg_write_wb !== 1'b0) $display("FAIL x0_wb: got we=%b, want 0", reg_write_wb);
        else n_pass++;
        drive_ex(5'd0, 1'b1, 1'b1, 32'h0000_0055);
        rs1_id = 5'd0;
        #1;
        n_total++;
        if (stall_id !== 1'b0) $display("FAIL x0_load_stall: got %b, want 0", stall_id);
        else n_pass++;
        drive_idle();
    endtask

    task automatic test_hold();
        drive_ex(5'd9, 1'b1, 1'b0, 32'h0000_000A);
        step();
        drive_ex(5'd10, 1'b1, 1'b0, 32'h0000_000B);
        step();
        // MEM holds r10/0xB, WB holds r9/0xA. Freeze with a load-use hazard
        // presented and a different EX instruction on the inputs.
        hold = 1'b1;
        drive_ex(5'd3, 1'b1, 1'b1, 32'h0000_0300);
        rs1_id = 5'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (rd_mem !== 5'd10 || alu_result_mem !== 32'hB || rd_wb !== 5'd9 || wb_data !== 32'hA ||
                reg_write_wb !== 1'b1 || stall_id !== 1'b1 || bubble_cnt !== 32'd1)
                $display("FAIL hold_cycle%0d: got mem=%0d/%h wb=%0d/%h we=%b stall=%b cnt=%0d, want 10/0000000b 9/0000000a 1 1 1",
                         i, rd_mem, alu_result_mem, rd_wb, wb_data, reg_write_wb, stall_id, bubble_cnt);
            else n_pass++;
        end
        drive_idle();
        hold = 1'b0;
        step();
        n_total++;
        if (rd_wb !== 5'd10 || wb_data !== 32'hB || reg_write_wb !== 1'b1 || reg_write_mem !== 1'b0 || bubble_cnt !== 32'd1)
            $display("FAIL hold_release: got wb=%0d/%h we_wb=%b we_mem=%b cnt=%0d, want 10/0000000b 1 0 1", rd_wb, wb_data, reg_write_wb, reg_write_mem, bubble_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive_ex(5'd12, 1'b1, 1'b1, 32'h0000_0200);
        step();
        drive_idle();
        n_total++;
        if (reg_write_mem !== 1'b1 || rd_mem !== 5'd12) $display("FAIL midrst_pre: got we=%b rd=%0d, want 1/12", reg_write_mem, rd_mem);
        else n_pass++;
        rst       = 1'b1;
        mem_rdata = 32'h0000_DEAD;
        step();
        rst       = 1'b0;
        mem_rdata = '0;
        n_total++;
        if ({rd_mem, reg_write_mem, fwd_ok_mem, alu_result_mem, rd_wb, reg_write_wb, wb_data} !== '0 || bubble_cnt !== 32'd0)
            $display("FAIL midrst_post: got mem=%0d/%b/%b/%h wb=%0d/%b/%h cnt=%0d, want all 0",
                     rd_mem, reg_write_mem, fwd_ok_mem, alu_result_mem, rd_wb, reg_write_wb, wb_data, bubble_cnt);
        else n_pass++;
        step();
        n_total++;
        if (reg_write_wb !== 1'b0 || wb_data !== 32'd0) $display("FAIL midrst_nowb: got we=%b data=%h, want 0/00000000", reg_write_wb, wb_data);
        else n_pass++;
    endtask

    task automatic test_saturation();
        // Continuous load-use stalls; the 3-bit counter tops out at 7.
        drive_ex(5'd7, 1'b1, 1'b1, 32'h0000_0400);
        rs1_id = 5'd7;
        for (int i = 0; i < 7; i++) step();
        n_total++;
        if (s_bubble_cnt !== 3'd7 || bubble_cnt !== 32'd7) $display("FAIL sat_reach: got small=%0d wide=%0d, want 7/7", s_bubble_cnt, bubble_cnt);
        else n_pass++;
        step();
        step();
        n_total++;
        if (s_bubble_cnt !== 3'd7) $display("FAIL sat_hold: got %0d, want 7", s_bubble_cnt);
        else n_pass++;
        n_total++;
        if (bubble_cnt !== 32'd9) $display("FAIL sat_wide_cnt: got %0d, want 9", bubble_cnt);
        else n_pass++;
        drive_idle();
    endtask

    initial begin
        rst  = 1'b1;
        hold = 1'b0;
        drive_idle();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_x0();
        test_hold();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fwd_source_pipe

// File: doc/fwd_source_pipe.md
Name: fwd_source_pipe

Overview:
Pipeline register pair that carries EX results through the MEM and WB stages. It produces the destination, write-enable and data values the forwarding logic and register file consume, and it detects load-use hazards against the ID stage. It sits between the EX stage (ALU output) and the register-file write port, with data memory attached at the MEM stage.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width
CNT_W, 32, width of the bubble counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
hold  in  1  global freeze (memory wait); no stage advances
ex_valid  in  1  EX holds a real instruction
rd_ex  in  REG_AW  EX destination register
reg_write_ex  in  1  EX instruction writes rd
mem_read_ex  in  1  EX instruction is a load
alu_result_ex  in  DATA_W  EX ALU output / load address
rs1_id  in  REG_AW  ID source 1
rs2_id  in  REG_AW  ID source 2
mem_rdata  in  DATA_W  data-memory read data, valid during the load's MEM cycle
rd_mem  out  REG_AW  MEM-stage destination
reg_write_mem  out  1  MEM write-enable, qualified
fwd_ok_mem  out  1  MEM value may be forwarded (not a load)
alu_result_mem  out  DATA_W  MEM-stage ALU value (also drives the memory address)
rd_wb  out  REG_AW  WB destination
reg_write_wb  out  1  WB write-enable, qualified
wb_data  out  DATA_W  register-file write data
stall_id  out  1  load-use stall request to PC/IF-ID
bubble_cnt  out  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset (rst=1 at edge): all valid bits 0; rd_*, data, and bubble_cnt 0; all outputs 0 on the following cycle. rst overrides hold.
- MEM register captures {ex_valid, rd_ex, reg_write_ex, mem_read_ex, alu_result_ex} each edge when hold=0.
- WB register captures the MEM fields each edge when hold=0. wb_data captures mem_rdata if the MEM entry is a load, otherwise alu_result_mem. mem_rdata is therefore sampled at the same edge that MEM advances.
- hold=1: both registers keep their values; bubble_cnt is unchanged; stall_id is still computed.
- Latency: an EX result appears on the MEM outputs 1 cycle later and on wb_data 2 cycles later, with no hold.
- Qualification, combinational from the registers:
  - reg_write_mem = valid_mem & reg_write_mem_q & (rd_mem != 0).
  - reg_write_wb is formed the same way for WB.
  - fwd_ok_mem = reg_write_mem & ~mem_read_mem_q.
- stall_id, combinational: stall_id = ex_valid & mem_read_ex & reg_write_ex & (rd_ex != 0) & ((rd_ex == rs1_id) | (rd_ex == rs2_id)).
- Upstream bubble insertion (holding PC and IF/ID, zeroing ID/EX) is done by the consumer of stall_id. This block only counts the bubbles.
- bubble_cnt increments when stall_id=1 and hold=0 at a clock edge. It saturates at all-ones and does not wrap.
- x0 never produces a write or forward, even if reg_write is set.
- When stall_id and hold are both 1, hold wins: there is no advance and no count.
- Reset applied mid-stream drops in-flight entries; no write-back is produced on the cycle after reset.

Decomposition:
- Shared pipeline package holds: REG_AW, DATA_W, the X0 address constant, and a mem_stage_t struct {valid, rd, reg_write, mem_read, data}.
- One sub-module, pipe_stage_reg: a parameterised register with hold and synchronous reset, instantiated for MEM and WB.
- Hazard compare and the counter stay in the top module.

Test Plan:
- ALU op rd_ex=5, alu_result_ex=0x1234, reg_write_ex=1.
  -> Cycle+1: rd_mem=5, reg_write_mem=1, fwd_ok_mem=1.
  -> Cycle+2: rd_wb=5, wb_data=0x1234, reg_write_wb=1.
- Load rd_ex=7, mem_read_ex=1, rs2_id=7.
  -> stall_id=1 in the same cycle.
  -> Next cycle: fwd_ok_mem=0; mem_rdata=0xCAFE is sampled.
  -> Cycle+2: wb_data=0xCAFE; bubble_cnt=1.
- Instruction with rd_ex=0 and reg_write_ex=1 (also as a load with rs1_id=0).
  -> reg_write_mem=0, reg_write_wb=0, stall_id=0.
- hold=1 for 3 cycles with entries in MEM and WB.
  -> Outputs are stable for all 3 cycles; bubble_cnt does not change while stall_id=1.
  -> After release, entries resume advancing.
- Assert rst while a load is in MEM.
  -> Next cycle: all outputs are 0 and no write-back occurs.
- Preload bubble_cnt near saturation (force or long run), then apply 2 more stalls.
  -> bubble_cnt holds at 0xFFFFFFFF.
